// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin arbiter sharing one 16-bit magnitude comparator
// (mag16) among NREQ requesters. Each grant takes three cycles:
// IDLE (grant and latch) -> CMP (compare) -> RESP (ack pulse).
// Optional build macro CMP_SIGNED_EN: compares the operands as
// two's-complement signed values. When it is undefined, the operands are
// compared as unsigned magnitudes.

// Combinational 16-bit magnitude comparator.
module mag16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gt_c,
    output logic        eq_c,
    output logic        lt_c
);
    assign gt_c = (a > b);
    assign eq_c = (a == b);
    assign lt_c = (a < b);
endmodule

module cmp_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*16-1:0]   opA,
    input  logic [NREQ*16-1:0]   opB,
    output logic [NREQ-1:0]      ack,
    output logic                 gt,
    output logic                 eq,
    output logic                 lt,
    output logic                 busy,
    output logic [PTR_W-1:0]     grant_id
);
    localparam int unsigned OPW = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_c;
    logic             win_vld_c;
    logic [OPW-1:0]   opa_q;
    logic [OPW-1:0]   opb_q;
    logic [OPW-1:0]   cmp_a_c;
    logic [OPW-1:0]   cmp_b_c;
    logic [OPW-1:0]   sel_a_c;
    logic [OPW-1:0]   sel_b_c;
    logic             gt_c;
    logic             eq_c;
    logic             lt_c;
    logic [OPW-1:0]   a_arr [NREQ];
    logic [OPW-1:0]   b_arr [NREQ];

    // Unpack the operand buses so the winner's operands can be selected by index.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            a_arr[i] = opA[i*OPW +: OPW];
            b_arr[i] = opB[i*OPW +: OPW];
        end
    end

    // Round-robin pick: the first set request found scanning upward from rr_ptr, with wrap.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_c     = '0;
        win_vld_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!win_vld_c && req[PTR_W'(idx)]) begin
                win_vld_c = 1'b1;
                win_c     = PTR_W'(idx);
            end
        end
    end

    assign sel_a_c = a_arr[win_c];
    assign sel_b_c = b_arr[win_c];

    // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
    assign cmp_a_c = opa_q ^ 16'h8000;
    assign cmp_b_c = opb_q ^ 16'h8000;
`else
    assign cmp_a_c = opa_q;
    assign cmp_b_c = opb_q;
`endif

    mag16 u_mag16 (
        .a    (cmp_a_c),
        .b    (cmp_b_c),
        .gt_c (gt_c),
        .eq_c (eq_c),
        .lt_c (lt_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: grant from IDLE, then a fixed CMP -> RESP -> IDLE sequence.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (win_vld_c) state_nx = ST_CMP;
            ST_CMP:  state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs: latch at grant, result and ack after CMP, advance the pointer in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= '0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else begin
            ack  <= '0;
            busy <= (state_nx != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (win_vld_c) begin
                        opa_q    <= sel_a_c;
                        opb_q    <= sel_b_c;
                        grant_id <= win_c;
                    end
                end
                ST_CMP: begin
                    gt  <= gt_c;
                    eq  <= eq_c;
                    lt  <= lt_c;
                    ack <= NREQ'(1) << grant_id;
                end
                ST_RESP: begin
                    rr_ptr <= (grant_id == PTR_W'(NREQ-1)) ? '0 : grant_id + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb (NREQ=4). The scoreboard queue holds the
// expected ack/result/grant for each grant in order. Build with +define+CMP_SIGNED_EN
// for the signed variant.
module tb_cmp_share_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned PTR_W = 2;

    typedef struct packed {
        logic [NREQ-1:0]  ack;
        logic             gt;
        logic             eq;
        logic             lt;
        logic [PTR_W-1:0] gid;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*16-1:0]   op_a;
    logic [NREQ*16-1:0]   op_b;
    logic [NREQ-1:0]      ack;
    logic                 gt;
    logic                 eq;
    logic                 lt;
    logic                 busy;
    logic [PTR_W-1:0]     grant_id;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t sb_e;

    cmp_share_arb #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .opA      (op_a),
        .opB      (op_b),
        .ack      (ack),
        .gt       (gt),
        .eq       (eq),
        .lt       (lt),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result for one compare, computed from the raw operands.
    function automatic exp_t mk(input int i, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.ack    = '0;
        e.ack[i] = 1'b1;
`ifdef CMP_SIGNED_EN
        e.gt = ($signed(a) >  $signed(b));
        e.eq = (a == b);
        e.lt = ($signed(a) <  $signed(b));
`else
        e.gt = (a > b);
        e.eq = (a == b);
        e.lt = (a < b);
`endif
        e.gid = PTR_W'(i);
        return e;
    endfunction

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        op_a[i*16 +: 16] = a;
        op_b[i*16 +: 16] = b;
    endtask

    // Bounded wait for ack[i]; returns the cycle stamp at which it was seen.
    task automatic wait_ack(input int i, output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[i] !== 1'b1 && n < 40);
        c = cyc;
        check($sformatf("ack%0d_seen", i), 32'(ack[i]), 32'd1);
    endtask

    // Monitor: every ack pops the scoreboard and is compared against it.
    always @(negedge clk) begin
        if (ack !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                sb_e = sb.pop_front();
                check("sb_ack", 32'(ack), 32'(sb_e.ack));
                check("sb_result", 32'({gt, eq, lt}), 32'({sb_e.gt, sb_e.eq, sb_e.lt}));
                check("sb_grant_id", 32'(grant_id), 32'(sb_e.gid));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int prev;
        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_res", 32'({gt, eq, lt}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request on requester 0: latency and busy width.
        set_op(0, 16'h0005, 16'h0003);
        sb.push_back(mk(0, 16'h0005, 16'h0003));
        req = 4'b0001;
        @(negedge clk);
        check("t1_busy_cmp", 32'(busy), 32'd1);
        check("t1_ack_cmp", 32'(ack), 32'd0);
        @(negedge clk);
        check("t1_busy_resp", 32'(busy), 32'd1);
        check("t1_ack_resp", 32'(ack), 32'b0001);
        req = 4'b0000;
        @(negedge clk);
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_ack_idle", 32'(ack), 32'd0);
        check("t1_gt_hold", 32'({gt, eq, lt}), 32'b100);

        // Requester 2, equal operands; req dropped and operands changed after grant.
        set_op(2, 16'h1234, 16'h1234);
        sb.push_back(mk(2, 16'h1234, 16'h1234));
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        set_op(2, 16'h0000, 16'h1234);
        wait_ack(2, c);
        @(negedge clk);
        check("t2_gid_hold", 32'(grant_id), 32'd2);

        // Requesters 0 and 3 together: the scan starts at 3, so 3 wins first.
        set_op(0, 16'h0010, 16'h0020);
        set_op(3, 16'h8000, 16'h7FFF);
        sb.push_back(mk(3, 16'h8000, 16'h7FFF));
        sb.push_back(mk(0, 16'h0010, 16'h0020));
        req = 4'b1001;
        wait_ack(3, c);
        req[3] = 1'b0;
        wait_ack(0, c);
        req[0] = 1'b0;
        @(negedge clk);

        // Reset during CMP aborts the compare with no ack.
        set_op(0, 16'h0001, 16'h0002);
        req = 4'b0001;
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_gid", 32'(grant_id), 32'd0);
        check("rst_mid_res", 32'({gt, eq, lt}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_noack", 32'(ack), 32'd0);
        set_op(1, 16'h4000, 16'h3FFF);
        sb.push_back(mk(1, 16'h4000, 16'h3FFF));
        req = 4'b0010;
        @(negedge clk);
        check("rst_fresh_ack_cmp", 32'(ack), 32'd0);
        @(negedge clk);
        check("rst_fresh_ack_resp", 32'(ack), 32'b0010);
        req = 4'b0000;
        @(negedge clk);

        // Plain reset pulse so the round-robin pointer starts again from 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_res", 32'({gt, eq, lt}), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);

        // All four requesters: service in order 0,1,2,3, three cycles apart.
        set_op(0, 16'h0100, 16'h0200);
        set_op(1, 16'h0300, 16'h0300);
        set_op(2, 16'hFFFE, 16'h0002);
        set_op(3, 16'h7000, 16'h9000);
        for (int i = 0; i < 4; i++) sb.push_back(mk(i, op_a[i*16 +: 16], op_b[i*16 +: 16]));
        req  = 4'b1111;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(i, c);
            req[i] = 1'b0;
            if (i > 0) check($sformatf("t3_spacing%0d", i), 32'(c - prev), 32'd3);
            prev = c;
        end
        @(negedge clk);

        // Requesters 1 and 3 held continuously: they must alternate.
        set_op(1, 16'h0042, 16'h0041);
        set_op(3, 16'h0007, 16'h0009);
        sb.push_back(mk(1, 16'h0042, 16'h0041));
        sb.push_back(mk(3, 16'h0007, 16'h0009));
        sb.push_back(mk(1, 16'h0042, 16'h0041));
        sb.push_back(mk(3, 16'h0007, 16'h0009));
        req = 4'b1010;
        wait_ack(1, c);
        wait_ack(3, c);
        wait_ack(1, c);
        wait_ack(3, c);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // 0xFFFF vs 0x0001: the result depends on signedness; operands change after grant.
        set_op(0, 16'hFFFF, 16'h0001);
        sb.push_back(mk(0, 16'hFFFF, 16'h0001));
        req = 4'b0001;
        @(negedge clk);
        set_op(0, 16'h0001, 16'h0001);
        wait_ack(0, c);
        req = 4'b0000;
`ifdef CMP_SIGNED_EN
        check("t5_signed_lt", 32'({gt, eq, lt}), 32'b001);
`else
        check("t5_unsigned_gt", 32'({gt, eq, lt}), 32'b100);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
